// File: rtl/display_page_scheduler.sv
// Rotates four requester pages onto the 4-digit display: saturates each page value, converts
// it to BCD by double-dabble, applies blanking and DP placement, and generates the mux refresh tick.
//
// state   | meaning
// IDLE    | no page enabled, display blank
// SELECT  | latch page value/DP, saturate
// CONVERT | 14 shift-add-3 iterations
// LOAD    | publish digits, dp_n, ovf, page_idx
// DWELL   | show page, count ticks, re-sample or rotate
module display_page_scheduler #(
    parameter int TICK_DIV   = 100000,
    parameter int PAGE_TICKS = 2000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  page_en,
    input  logic [15:0] page_val0,
    input  logic [15:0] page_val1,
    input  logic [15:0] page_val2,
    input  logic [15:0] page_val3,
    input  logic [7:0]  page_dp,
    output logic [6:0]  dig0,
    output logic [6:0]  dig1,
    output logic [6:0]  dig2,
    output logic [6:0]  dig3,
    output logic [3:0]  dp_n,
    output logic        mux_tick,
    output logic [1:0]  page_idx,
    output logic        ovf,
    output logic        busy
);
    localparam int TW = $clog2(TICK_DIV);
    localparam int DW = $clog2(PAGE_TICKS + 1);
    localparam logic [6:0] BLANK = 7'b1111111;

    typedef enum logic [2:0] {IDLE, SELECT, CONVERT, LOAD, DWELL} state_t;

    state_t        state, state_nxt;
    logic [1:0]    sel, sel_nxt;
    logic          dwell_clr, go_blank;
    logic [TW-1:0] tick_cnt;
    logic [DW-1:0] dwell_cnt;
    logic [13:0]   bin;
    logic [15:0]   bcd, bcd_adj;
    logic [3:0]    conv_cnt;
    logic [1:0]    dp_sel;
    logic          ovf_pend;
    logic [15:0]   sel_val;
    logic          z3, z2, z1;

    // First enabled page strictly after cur, wrapping; cur itself is the last candidate.
    function automatic logic [1:0] next_page(input logic [3:0] en, input logic [1:0] cur);
        logic [1:0] cand;
        next_page = cur;
        for (int i = 4; i >= 1; i--) begin
            cand = cur + 2'(i);
            if (en[cand]) next_page = cand;
        end
    endfunction

    function automatic logic [6:0] seg(input logic [3:0] d);
        case (d)
            4'd0:    seg = 7'b0000001;
            4'd1:    seg = 7'b1001111;
            4'd2:    seg = 7'b0010010;
            4'd3:    seg = 7'b0000110;
            4'd4:    seg = 7'b1001100;
            4'd5:    seg = 7'b0100100;
            4'd6:    seg = 7'b0100000;
            4'd7:    seg = 7'b0001111;
            4'd8:    seg = 7'b0000000;
            4'd9:    seg = 7'b0000100;
            default: seg = BLANK;
        endcase
    endfunction

    assign mux_tick = (tick_cnt == TW'(TICK_DIV - 1));
    assign busy     = (state == SELECT) || (state == CONVERT) || (state == LOAD);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            sel   <= 2'd0;
        end else begin
            state <= state_nxt;
            sel   <= sel_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        sel_nxt   = sel;
        dwell_clr = 1'b0;
        go_blank  = 1'b0;
        case (state)
            IDLE: begin
                if (page_en != 4'd0) begin
                    state_nxt = SELECT;
                    sel_nxt   = next_page(page_en, 2'd3);
                end
            end
            SELECT:  state_nxt = CONVERT;
            CONVERT: if (conv_cnt == 4'd13) state_nxt = LOAD;
            LOAD:    state_nxt = DWELL;
            DWELL: begin
                if (mux_tick) begin
                    state_nxt = SELECT;
                    if (page_en == 4'd0) begin
                        state_nxt = IDLE;
                        go_blank  = 1'b1;
                        dwell_clr = 1'b1;
                    end else if (!page_en[sel] || dwell_cnt >= DW'(PAGE_TICKS - 1)) begin
                        sel_nxt   = next_page(page_en, sel);
                        dwell_clr = 1'b1;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        case (sel)
            2'd0:    sel_val = page_val0;
            2'd1:    sel_val = page_val1;
            2'd2:    sel_val = page_val2;
            default: sel_val = page_val3;
        endcase
    end

    always_comb begin
        for (int n = 0; n < 4; n++) begin
            bcd_adj[4*n +: 4] = (bcd[4*n +: 4] >= 4'd5) ? bcd[4*n +: 4] + 4'd3 : bcd[4*n +: 4];
        end
    end

    // A digit blanks only while it and everything left of it is zero and it sits left of the DP.
    always_comb begin
        z3 = (bcd[15:12] == 4'd0) && (dp_sel < 2'd3);
        z2 = z3 && (bcd[11:8] == 4'd0) && (dp_sel < 2'd2);
        z1 = z2 && (bcd[7:4] == 4'd0) && (dp_sel < 2'd1);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tick_cnt  <= '0;
            dwell_cnt <= '0;
            bin       <= '0;
            bcd       <= '0;
            conv_cnt  <= '0;
            dp_sel    <= '0;
            ovf_pend  <= 1'b0;
            dig0      <= BLANK;
            dig1      <= BLANK;
            dig2      <= BLANK;
            dig3      <= BLANK;
            dp_n      <= 4'b1111;
            page_idx  <= 2'd0;
            ovf       <= 1'b0;
        end else begin
            tick_cnt <= mux_tick ? '0 : tick_cnt + TW'(1);
            if (dwell_clr)
                dwell_cnt <= '0;
            else if (mux_tick && state != IDLE && dwell_cnt < DW'(PAGE_TICKS))
                dwell_cnt <= dwell_cnt + DW'(1);

            if (state == SELECT) begin
                ovf_pend <= (sel_val > 16'd9999);
                bin      <= (sel_val > 16'd9999) ? 14'd9999 : sel_val[13:0];
                bcd      <= '0;
                conv_cnt <= '0;
                dp_sel   <= page_dp[{sel, 1'b0} +: 2];
            end
            if (state == CONVERT) begin
                {bcd, bin} <= {bcd_adj, bin} << 1;
                conv_cnt   <= conv_cnt + 4'd1;
            end
            if (state == LOAD) begin
                dig3     <= z3 ? BLANK : seg(bcd[15:12]);
                dig2     <= z2 ? BLANK : seg(bcd[11:8]);
                dig1     <= z1 ? BLANK : seg(bcd[7:4]);
                dig0     <= seg(bcd[3:0]);
                dp_n     <= (dp_sel == 2'd0) ? 4'b1111 : ~(4'b0001 << dp_sel);
                ovf      <= ovf_pend;
                page_idx <= sel;
            end
            if (go_blank) begin
                dig0 <= BLANK;
                dig1 <= BLANK;
                dig2 <= BLANK;
                dig3 <= BLANK;
                dp_n <= 4'b1111;
                ovf  <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_display_page_scheduler.sv
// Scoreboard bench for display_page_scheduler: expected loads are queued by the stimulus
// and checked by a monitor on every busy falling edge.
module tb_display_page_scheduler;
    localparam int TICK_DIV   = 32;
    localparam int PAGE_TICKS = 4;

    localparam logic [6:0] S0 = 7'b0000001, S1 = 7'b1001111, S2 = 7'b0010010, S3 = 7'b0000110;
    localparam logic [6:0] S4 = 7'b1001100, S5 = 7'b0100100, S6 = 7'b0100000, S7 = 7'b0001111;
    localparam logic [6:0] S8 = 7'b0000000, S9 = 7'b0000100, SB = 7'b1111111;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  page_en;
    logic [15:0] page_val0, page_val1, page_val2, page_val3;
    logic [7:0]  page_dp;
    logic [6:0]  dig0, dig1, dig2, dig3;
    logic [3:0]  dp_n;
    logic        mux_tick;
    logic [1:0]  page_idx;
    logic        ovf;
    logic        busy;

    display_page_scheduler #(.TICK_DIV(TICK_DIV), .PAGE_TICKS(PAGE_TICKS)) dut (
        .clk(clk), .reset(reset), .page_en(page_en),
        .page_val0(page_val0), .page_val1(page_val1), .page_val2(page_val2), .page_val3(page_val3),
        .page_dp(page_dp), .dig0(dig0), .dig1(dig1), .dig2(dig2), .dig3(dig3), .dp_n(dp_n),
        .mux_tick(mux_tick), .page_idx(page_idx), .ovf(ovf), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [27:0] digs;
        logic [3:0]  dpn;
        logic        ov;
        logic [1:0]  pidx;
    } exp_t;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    task automatic push(input logic [6:0] d3, input logic [6:0] d2, input logic [6:0] d1,
                        input logic [6:0] d0, input logic [3:0] dpn, input logic ov,
                        input logic [1:0] pidx);
        exp_t e;
        e.digs = {d3, d2, d1, d0};
        e.dpn  = dpn;
        e.ov   = ov;
        e.pidx = pidx;
        sb.push_back(e);
    endtask

    task automatic wait_drain(input string name);
        int t = 0;
        while (sb.size() != 0 && t < 200) begin
            @(negedge clk);
            t++;
        end
        check({name, "_drained"}, 32'(sb.size()), 32'd0);
        sb.delete();
    endtask

    task automatic vec0(input logic [15:0] v, input logic [1:0] dp, input logic [6:0] d3,
                        input logic [6:0] d2, input logic [6:0] d1, input logic [6:0] d0,
                        input logic [3:0] dpn, input logic ov);
        page_val0 = v;
        page_dp   = {6'b0, dp};
        push(d3, d2, d1, d0, dpn, ov, 2'd0);
        wait_drain("vec0");
    endtask

    task automatic check_blank(input string name);
        check({name, "_digits"}, 32'({dig3, dig2, dig1, dig0}), 32'({SB, SB, SB, SB}));
        check({name, "_dp_n"}, 32'(dp_n), 32'hF);
        check({name, "_ovf"}, 32'(ovf), 32'd0);
        check({name, "_busy"}, 32'(busy), 32'd0);
    endtask

    // Monitor: one scoreboard entry per completed conversion; also checks busy width and tick period.
    int   mon_run = 0;
    logic mon_pb = 1'b0;
    int   tick_gap = 0;
    bit   tick_seen = 1'b0;
    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (reset) begin
                mon_run   = 0;
                mon_pb    = 1'b0;
                tick_gap  = 0;
                tick_seen = 1'b0;
            end else begin
                tick_gap++;
                if (mux_tick) begin
                    if (tick_seen) check("tick_period", 32'(tick_gap), 32'(TICK_DIV));
                    tick_gap  = 0;
                    tick_seen = 1'b1;
                end
                if (busy) mon_run++;
                if (mon_pb && !busy) begin
                    check("busy_cycles", 32'(mon_run), 32'd16);
                    if (sb.size() == 0) begin
                        check("unexpected_load", 32'd1, 32'(sb.size()));
                    end else begin
                        e = sb.pop_front();
                        check("load_digits", 32'({dig3, dig2, dig1, dig0}), 32'(e.digs));
                        check("load_dp_n", 32'(dp_n), 32'(e.dpn));
                        check("load_ovf", 32'(ovf), 32'(e.ov));
                        check("load_page_idx", 32'(page_idx), 32'(e.pidx));
                    end
                    mon_run = 0;
                end
                mon_pb = busy;
            end
        end
    end

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: simulation did not end, required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        int t;
        bit busy_seen;
        reset     = 1'b1;
        page_en   = 4'b0001;
        page_val0 = 16'd1234;
        page_val1 = 16'd0;
        page_val2 = 16'd0;
        page_val3 = 16'd0;
        page_dp   = 8'd0;
        repeat (3) @(negedge clk);
        check("rst_digits", 32'({dig3, dig2, dig1, dig0}), 32'({SB, SB, SB, SB}));
        check("rst_dp_n", 32'(dp_n), 32'hF);
        check("rst_mux_tick", 32'(mux_tick), 32'd0);
        check("rst_page_idx", 32'(page_idx), 32'd0);
        check("rst_ovf", 32'(ovf), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);

        push(S1, S2, S3, S4, 4'b1111, 1'b0, 2'd0);
        reset = 1'b0;
        wait_drain("first_1234");

        vec0(16'd7,     2'd0, SB, SB, SB, S7, 4'b1111, 1'b0);
        vec0(16'd0,     2'd0, SB, SB, SB, S0, 4'b1111, 1'b0);
        vec0(16'd100,   2'd0, SB, S1, S0, S0, 4'b1111, 1'b0);
        vec0(16'd9999,  2'd0, S9, S9, S9, S9, 4'b1111, 1'b0);
        vec0(16'd10000, 2'd0, S9, S9, S9, S9, 4'b1111, 1'b1);
        vec0(16'd12000, 2'd0, S9, S9, S9, S9, 4'b1111, 1'b1);
        vec0(16'd65535, 2'd2, S9, S9, S9, S9, 4'b1011, 1'b1);
        vec0(16'd42,    2'd0, SB, SB, S4, S2, 4'b1111, 1'b0);
        vec0(16'd5,     2'd1, SB, SB, S0, S5, 4'b1101, 1'b0);
        vec0(16'd50,    2'd3, S0, S0, S5, S0, 4'b0111, 1'b0);
        vec0(16'd3,     2'd2, SB, S0, S0, S3, 4'b1011, 1'b0);

        // Rotation over pages 0,1,3 from a fresh reset.
        @(negedge clk);
        reset     = 1'b1;
        page_en   = 4'b1011;
        page_val0 = 16'd11;
        page_val1 = 16'd222;
        page_val2 = 16'd8;
        page_val3 = 16'd3333;
        page_dp   = 8'b01_00_00_00;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin push(SB, SB, S1, S1, 4'b1111, 1'b0, 2'd0); wait_drain("rot_p0"); end
        for (int i = 0; i < 4; i++) begin push(SB, S2, S2, S2, 4'b1111, 1'b0, 2'd1); wait_drain("rot_p1"); end
        for (int i = 0; i < 4; i++) begin push(S3, S3, S3, S3, 4'b1101, 1'b0, 2'd3); wait_drain("rot_p3"); end
        for (int i = 0; i < 4; i++) begin push(SB, SB, S1, S1, 4'b1111, 1'b0, 2'd0); wait_drain("rot_p0b"); end
        push(SB, S2, S2, S2, 4'b1111, 1'b0, 2'd1);
        wait_drain("rot_p1b");
        page_en = 4'b1001;
        push(S3, S3, S3, S3, 4'b1101, 1'b0, 2'd3);
        wait_drain("skip_to_p3");

        // All pages dropped: blank at the next tick, then stay idle.
        page_en = 4'b0000;
        t = 0;
        while (!mux_tick && t < 100) begin @(negedge clk); t++; end
        check("collapse_tick_seen", 32'(mux_tick), 32'd1);
        @(negedge clk);
        check_blank("collapse");
        busy_seen = 1'b0;
        repeat (80) begin @(negedge clk); if (busy) busy_seen = 1'b1; end
        check("idle_no_busy", 32'(busy_seen), 32'd0);
        check_blank("idle_hold");

        // Reset in the middle of a conversion.
        page_val0 = 16'd1234;
        page_dp   = 8'd0;
        page_en   = 4'b0001;
        push(S1, S2, S3, S4, 4'b1111, 1'b0, 2'd0);
        wait_drain("pre_abort");
        t = 0;
        while (!busy && t < 100) begin @(negedge clk); t++; end
        check("abort_busy_seen", 32'(busy), 32'd1);
        repeat (5) @(negedge clk);
        reset = 1'b1;
        #1;
        check_blank("abort");
        check("abort_mux_tick", 32'(mux_tick), 32'd0);
        page_val0 = 16'd8765;
        page_dp   = 8'b0000_0010;
        repeat (2) @(negedge clk);
        push(S8, S7, S6, S5, 4'b1011, 1'b0, 2'd0);
        reset = 1'b0;
        wait_drain("post_abort");

        repeat (4) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
